// File: rtl/memory_pipe.sv
// Single-port synchronous memory with byte enables, valid/ready requests, a pipelined
// read path of RLAT stages and a hardware sweep that fills every word with INIT_VAL.
module memory_pipe #(
  parameter int unsigned        AWIDTH   = 5,
  parameter int unsigned        DWIDTH   = 8,
  parameter int unsigned        RLAT     = 1,
  parameter logic [DWIDTH-1:0]  INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [AWIDTH-1:0]   req_addr,
  input  logic [DWIDTH-1:0]   req_wdata,
  input  logic [DWIDTH/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DWIDTH-1:0]   rsp_rdata,
  input  logic                init_start,
  output logic                init_busy
);

  localparam int unsigned NBYTES = DWIDTH / 8;
  localparam int unsigned DEPTH  = 2 ** AWIDTH;

  typedef enum logic [0:0] {StInit, StIdle} state_e;

  state_e              r_state;
  logic [AWIDTH-1:0]   r_cnt;
  logic                r_ready;
  logic                r_busy;
  logic [DWIDTH-1:0]   r_mem [DEPTH];
  logic [RLAT-1:0]     r_vld;
  logic [DWIDTH-1:0]   r_dat [RLAT];

  logic w_acc;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_sweep_we;

  assign w_acc      = req_valid & r_ready;
  assign w_wr_acc   = w_acc & req_wr;
  assign w_rd_acc   = w_acc & ~req_wr;
  assign w_sweep_we = (r_state == StInit);

  // Sweep sequencer; the last address is detected explicitly so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StInit;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      unique case (r_state)
        StInit: begin
          if (r_cnt == '1) begin
            r_state <= StIdle;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + AWIDTH'(1);
          end
        end
        StIdle: begin
          if (init_start) begin
            r_state <= StInit;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= StInit;
          r_cnt   <= '0;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; only the sweep and writes define its contents.
  always_ff @(posedge clk) begin
    if (w_sweep_we) begin
      r_mem[r_cnt] <= INIT_VAL;
    end else if (w_wr_acc) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (req_be[i]) begin
          r_mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Data stages only advance behind a valid, so the last stage holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < RLAT; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_dat[0] <= r_mem[req_addr];
      end
      for (int unsigned i = 1; i < RLAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  end

  assign req_ready = r_ready;
  assign init_busy = r_busy;
  assign rsp_valid = r_vld[RLAT-1];
  assign rsp_rdata = r_dat[RLAT-1];

endmodule
